// File: rtl/icu_pkg.sv
// Shared definitions for the interrupt control unit.
// Holds the register address map and the upper bound on the number of
// interrupt sources.
package icu_pkg;

  localparam logic [1:0] ICU_ADDR_PEND = 2'd0;
  localparam logic [1:0] ICU_ADDR_EN   = 2'd1;
  localparam logic [1:0] ICU_ADDR_ACT  = 2'd2;
  localparam logic [1:0] ICU_ADDR_EDGE = 2'd3;

  localparam int ICU_MAX_SRC = 32;
  localparam int ICU_IDX_W   = 5;

endpackage

// File: rtl/icu_prio_enc.sv
// Combinational priority encoder for the ICU active-source register.
// Ports:
//   req   - request vector, NUM_SRC bits
//   valid - high when any request bit is set
//   idx   - index of the lowest set request bit, 0 when none is set
module icu_prio_enc
  import icu_pkg::*;
#(
  parameter int NUM_SRC = 16
) (
  input  logic [NUM_SRC-1:0]   req,
  output logic                 valid,
  output logic [ICU_IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set bit is the last one assigned.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = ICU_IDX_W'(i);
    end
  end

endmodule

// File: rtl/icu.sv
// Interrupt control unit: merges per-peripheral interrupt requests into a
// single registered CPU interrupt line.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   stb, we, addr     - single-cycle peripheral bus access
//   data_in, data_out - bus write data / combinational read data
//   ack               - bus acknowledge, equal to stb
//   irq_in            - peripheral requests, one bit per source
//   irq               - registered CPU interrupt request
// Registers: 0 PENDING (W1C, edge sources only), 1 ENABLE, 2 ACTIVE (RO),
// 3 EDGE (1 = rising edge, 0 = level).
// Build option: define ICU_PRIORITY_EN to include the priority encoder and
// the ACTIVE register; otherwise address 2 reads zero.
module icu
  import icu_pkg::*;
#(
  parameter int NUM_SRC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stb,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               ack,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic               irq_q, irq_d;

  logic [NUM_SRC-1:0] src_wr;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] pend_edge;
  logic               wr;

  logic [ICU_MAX_SRC-1:0] pend_rd, en_rd, edge_rd, act_rd;

  // Write data above NUM_SRC is intentionally discarded.
  logic unused_data;
  assign unused_data = ^data_in;

  assign ack = stb;
  assign irq = irq_q;

  always_comb begin
    wr       = stb & we;
    src_wr   = data_in[NUM_SRC-1:0];
    w1c      = (wr && addr == ICU_ADDR_PEND) ? src_wr : '0;
    prev_d   = irq_in;
    enable_d = enable_q;
    edge_d   = edge_q;

    // Edge sources: a new rising edge wins over a same-cycle clear.
    pend_edge = (irq_in & ~prev_q) | (pending_q & ~w1c);
    pending_d = (edge_q & pend_edge) | (~edge_q & irq_in);

    if (wr && addr == ICU_ADDR_EN) enable_d = src_wr;
    if (wr && addr == ICU_ADDR_EDGE) begin
      edge_d    = src_wr;
      // Changing a source's mode discards whatever it had pending.
      pending_d = pending_d & ~(edge_q ^ src_wr);
    end

    irq_d = |(pending_q & enable_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      prev_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      prev_q    <= prev_d;
      irq_q     <= irq_d;
    end
  end

`ifdef ICU_PRIORITY_EN
  logic [NUM_SRC-1:0]   act_req;
  logic                 act_valid;
  logic [ICU_IDX_W-1:0] act_idx;

  assign act_req = pending_q & enable_q;

  icu_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req   (act_req),
    .valid (act_valid),
    .idx   (act_idx)
  );

  assign act_rd = {act_valid, 26'b0, act_idx};
`else
  assign act_rd = '0;
`endif

  always_comb begin
    pend_rd = '0;
    en_rd   = '0;
    edge_rd = '0;
    pend_rd[NUM_SRC-1:0] = pending_q;
    en_rd[NUM_SRC-1:0]   = enable_q;
    edge_rd[NUM_SRC-1:0] = edge_q;
    case (addr)
      ICU_ADDR_PEND: data_out = pend_rd;
      ICU_ADDR_EN:   data_out = en_rd;
      ICU_ADDR_ACT:  data_out = act_rd;
      default:       data_out = edge_rd;
    endcase
  end

endmodule

// File: tb/tb_icu.sv
module tb_icu;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic [15:0] irq_in;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  icu #(.NUM_SRC(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .irq_in   (irq_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    tick();
    stb = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    stb = 1'b0; we = 1'b0; addr = a;
    #1;
    chk(tag, data_out, exp);
  endtask

  initial begin
    logic [31:0] act_exp1, act_exp2;
`ifdef ICU_PRIORITY_EN
    act_exp1 = 32'h8000_0003;
    act_exp2 = 32'h8000_0005;
`else
    act_exp1 = 32'h0;
    act_exp2 = 32'h0;
`endif

    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; data_in = '0; irq_in = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    rd("rst_pend", 2'd0, 32'h0);
    rd("rst_en",   2'd1, 32'h0);
    rd("rst_act",  2'd2, 32'h0);
    rd("rst_edge", 2'd3, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // Bus acknowledge follows strobe
    stb = 1'b1; #1;
    chk("ack_hi", {31'b0, ack}, 32'h1);
    stb = 1'b0; #1;
    chk("ack_lo", {31'b0, ack}, 32'h0);

    // Level source 0
    wr(2'd1, 32'h1);
    irq_in = 16'h0001;              // cycle k
    tick();                          // k+1
    rd("lvl_pend_k1", 2'd0, 32'h1);
    chk("lvl_irq_k1", {31'b0, irq}, 32'h0);
    tick();                          // k+2
    chk("lvl_irq_k2", {31'b0, irq}, 32'h1);
    wr(2'd0, 32'h1);                 // W1C ignored on level source
    rd("lvl_w1c_pend", 2'd0, 32'h1);
    chk("lvl_w1c_irq", {31'b0, irq}, 32'h1);
    irq_in = 16'h0000;              // cycle m
    tick();
    chk("lvl_drop_m1", {31'b0, irq}, 32'h1);
    tick();
    chk("lvl_drop_m2", {31'b0, irq}, 32'h0);

    // Edge source 2: single-cycle pulse
    wr(2'd3, 32'h4);
    wr(2'd1, 32'h4);
    rd("edge_mode_rd", 2'd3, 32'h4);
    irq_in = 16'h0004;
    tick();
    irq_in = 16'h0000;
    rd("edge_pend_set", 2'd0, 32'h4);
    tick(); tick();
    rd("edge_pend_hold", 2'd0, 32'h4);
    chk("edge_irq_hi", {31'b0, irq}, 32'h1);
    wr(2'd0, 32'h4);                 // W1C in cycle w
    rd("edge_w1c_pend", 2'd0, 32'h0);
    chk("edge_w1c_irq1", {31'b0, irq}, 32'h1);
    tick();
    chk("edge_w1c_irq2", {31'b0, irq}, 32'h0);

    // Held edge input sets only once
    irq_in = 16'h0004;
    tick();
    rd("hold_pend_set", 2'd0, 32'h4);
    wr(2'd0, 32'h4);
    rd("hold_pend_clr", 2'd0, 32'h0);
    tick(); tick();
    rd("hold_no_reset", 2'd0, 32'h0);
    irq_in = 16'h0000;
    tick();

    // Same-cycle set and clear: set wins
    irq_in = 16'h0004;
    wr(2'd0, 32'h4);
    rd("set_wins", 2'd0, 32'h4);
    irq_in = 16'h0000;
    wr(2'd0, 32'h4);
    rd("set_wins_clr", 2'd0, 32'h0);

    // Priority among level sources 3, 5, 9
    irq_in = 16'h0228;
    tick();
    rd("prio_pend", 2'd0, 32'h228);
    wr(2'd1, 32'h228);
    rd("prio_act1", 2'd2, act_exp1);
    wr(2'd1, 32'hFFFF_0220);        // upper bits ignored
    rd("en_upper", 2'd1, 32'h220);
    rd("prio_act2", 2'd2, act_exp2);
    wr(2'd2, 32'hFFFF_FFFF);        // ACTIVE is read-only
    rd("act_ro_en", 2'd1, 32'h220);
    irq_in = 16'h0000;
    tick();

    // Mode change clears pending even with input held high
    irq_in = 16'h0004;
    tick();
    rd("mode_pend_set", 2'd0, 32'h4);
    wr(2'd3, 32'h0);
    rd("mode_pend_clr", 2'd0, 32'h0);
    tick();
    rd("mode_level", 2'd0, 32'h4);
    irq_in = 16'h0000;
    tick();

    // Reset during active irq
    wr(2'd1, 32'h1);
    wr(2'd3, 32'h8);
    irq_in = 16'h0001;
    tick(); tick();
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rst2_irq", {31'b0, irq}, 32'h0);
    rd("rst2_pend", 2'd0, 32'h0);
    rd("rst2_en",   2'd1, 32'h0);
    rd("rst2_act",  2'd2, 32'h0);
    rd("rst2_edge", 2'd3, 32'h0);
    rst = 1'b0;
    irq_in = 16'h0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
